fault_injection_unit: RTL and testbench
=======================================

Name: fault_injection_unit

Overview:
Parametrised, timed fault injector inserted on an NVDLA datapath or control bus of arbitrary width. Generalises the fixed 18-bit select-mux with a per-bit mask and four corruption modes. Adds a programmable trigger delay and a programmable fault duration, counted in clock cycles or in valid beats. Runs from an arm/disarm state machine and reports status for the fault-campaign software.

Parameters:
WIDTH, 18, datapath width in bits
CNT_W, 32, width of the delay, duration and inject counters

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rst  input  1  synchronous reset, active-high
cdata_in  input  WIDTH  clean data from the upstream stage
cdata_valid  input  1  beat qualifier for cdata_in
out  output  WIDTH  data to the downstream stage, possibly corrupted
cfg_mask  input  WIDTH  bits to corrupt; 1 = corrupt this bit
cfg_mode  input  2  00 stuck-at-0, 01 stuck-at-1, 10 bit-flip, 11 pattern
cfg_pattern  input  WIDTH  replacement value used in pattern mode
cfg_delay  input  CNT_W  events to wait after arm before the fault starts
cfg_duration  input  CNT_W  events the fault lasts; 0 = permanent
cfg_trig_sel  input  1  event unit: 0 = clock cycles, 1 = valid beats
arm  input  1  start pulse; latches all cfg_* inputs
disarm  input  1  abort pulse; returns the block to IDLE
fi_armed  output  1  high in ARMED
fi_active  output  1  high in ACTIVE
fi_done  output  1  high in DONE
inject_count  output  CNT_W  number of corrupted events, saturating

Behaviour:
- Interface: one clock, nvdla_core_clk. Reset nvdla_core_rst is synchronous and active-high.
- Reset values: state IDLE; all counters 0; latched config 0. fi_armed, fi_active and fi_done are 0; inject_count is 0.
- Datapath: zero latency and combinational from cdata_in.
  - out = cdata_in when state is not ACTIVE.
  - In ACTIVE, for each bit i with mask_q[i]=1:
    - mode 00 -> 0
    - mode 01 -> 1
    - mode 10 -> ~cdata_in[i]
    - mode 11 -> pattern_q[i]
  - Bits with mask_q[i]=0 always pass through unchanged.
  - Only the registered state and latched config select corruption. Live cfg_* inputs never affect out.
- Event: when cfg_trig_sel_q=0, an event occurs every cycle; when cfg_trig_sel_q=1, an event is a cycle with cdata_valid=1.
- States:
  - IDLE: on arm -> latch cfg_*, load cnt = cfg_delay. Go to ACTIVE if cfg_delay==0, else ARMED.
  - ARMED: on an event, cnt decrements. When an event arrives with cnt==1, next state is ACTIVE and cnt is loaded with duration_q.
  - ACTIVE: on an event, inject_count increments, saturating at 2^CNT_W-1.
    - If duration_q!=0, cnt decrements. An event with cnt==1 moves the state to DONE.
    - If duration_q==0, the block stays in ACTIVE until disarm.
  - DONE: holds until the next arm or disarm. arm here re-latches config, behaves as arm from IDLE, and clears inject_count.
- arm from IDLE clears inject_count.
- arm while in ARMED or ACTIVE is ignored.
- disarm in any state -> IDLE next cycle; inject_count is held.
- disarm and arm in the same cycle: disarm wins.
- cfg_delay==0: the first corrupted cycle is the cycle after arm.
- Duration D>0 corrupts exactly D events.
- Reset mid-operation: the next cycle is in IDLE, out is clean, and all status outputs are 0.
- Status outputs are registered decodes of state and are mutually exclusive.
- In beat mode, cycles without valid do not advance the counters. Data is still corrupted in ACTIVE regardless of valid.

Decomposition:
- Package fault_injection_pkg:
  - mode encodings FI_STUCK0, FI_STUCK1, FI_FLIP, FI_PATTERN
  - state encodings FI_IDLE, FI_ARMED, FI_ACTIVE, FI_DONE
  - trigger select constants FI_TRIG_CYCLE, FI_TRIG_BEAT
- Sub-module fault_injection_corrupt:
  - purely combinational, parameter WIDTH
  - inputs: data, mask, mode, pattern, en
  - output: corrupted data
  - The top level holds the FSM, counters and config registers.

Test Plan:
- WIDTH=18, mode 10, mask=0x00001, delay=0, duration=3, cycle trigger, cdata_in=0x15555 -> out=0x15554 for the 3 cycles after arm, then 0x15555. fi_done=1, inject_count=3.
- Mode 00, mask=0x3FFFF, delay=5, duration=2, beat trigger, valid every other cycle -> out stays clean until the 5th valid beat has passed. It is then 0x00000 across 2 valid beats, with the invalid cycle in between also corrupted.
- Mode 11, pattern=0x0F0F0, mask=0x000FF, duration=0 -> out=(cdata_in&0x3FF00)|0x000F0 indefinitely. disarm -> clean next cycle, fi_active=0, inject_count holds.
- arm and disarm in the same cycle from IDLE -> state stays IDLE and out stays clean.
- A second arm in ARMED is ignored. Changing cfg_mask while ACTIVE does not change out.
- nvdla_core_rst asserted for one cycle mid-ACTIVE with mode 01 -> the next cycle shows out==cdata_in, all status outputs 0, and inject_count=0.

Source files
------------

// File: rtl/fault_injection_pkg.sv
// rtl/fault_injection_pkg.sv - shared encodings for the fault injection unit
package fault_injection_pkg;

    localparam logic [1:0] FI_STUCK0  = 2'b00;
    localparam logic [1:0] FI_STUCK1  = 2'b01;
    localparam logic [1:0] FI_FLIP    = 2'b10;
    localparam logic [1:0] FI_PATTERN = 2'b11;

    localparam logic [1:0] FI_IDLE   = 2'b00;
    localparam logic [1:0] FI_ARMED  = 2'b01;
    localparam logic [1:0] FI_ACTIVE = 2'b10;
    localparam logic [1:0] FI_DONE   = 2'b11;

    localparam logic FI_TRIG_CYCLE = 1'b0;
    localparam logic FI_TRIG_BEAT  = 1'b1;

endpackage

// File: rtl/fault_injection_corrupt.sv
// rtl/fault_injection_corrupt.sv - combinational per-bit corruption of a data word
module fault_injection_corrupt
    import fault_injection_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] mask,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pattern,
    input  logic             en,
    output logic [WIDTH-1:0] corrupted
);

    always_comb begin
        corrupted = data;
        if (en) begin
            case (mode)
                FI_STUCK0:  corrupted = data & ~mask;
                FI_STUCK1:  corrupted = data | mask;
                FI_FLIP:    corrupted = data ^ mask;
                FI_PATTERN: corrupted = (data & ~mask) | (pattern & mask);
                default:    corrupted = data;
            endcase
        end
    end

endmodule

// File: rtl/fault_injection_unit.sv
// rtl/fault_injection_unit.sv - timed, masked fault injector with arm/disarm control
module fault_injection_unit
    import fault_injection_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int CNT_W = 32
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [WIDTH-1:0] cdata_in,
    input  logic             cdata_valid,
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_duration,
    input  logic             cfg_trig_sel,
    input  logic             arm,
    input  logic             disarm,
    output logic             fi_armed,
    output logic             fi_active,
    output logic             fi_done,
    output logic [CNT_W-1:0] inject_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, count_d;
    logic [WIDTH-1:0] mask_q, pattern_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] duration_q;
    logic             trig_sel_q;
    logic             load_cfg;
    logic             ev;

    assign ev = (trig_sel_q == FI_TRIG_BEAT) ? cdata_valid : 1'b1;

    // disarm outranks everything, including a simultaneous arm
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        count_d  = inject_count;
        load_cfg = 1'b0;
        if (disarm) begin
            state_d = FI_IDLE;
        end else begin
            case (state)
                FI_IDLE, FI_DONE: begin
                    if (arm) begin
                        load_cfg = 1'b1;
                        count_d  = '0;
                        if (cfg_delay == '0) begin
                            state_d = FI_ACTIVE;
                            cnt_d   = cfg_duration;
                        end else begin
                            state_d = FI_ARMED;
                            cnt_d   = cfg_delay;
                        end
                    end
                end
                FI_ARMED: begin
                    if (ev) begin
                        if (cnt == CNT_ONE) begin
                            state_d = FI_ACTIVE;
                            cnt_d   = duration_q;
                        end else begin
                            cnt_d = cnt - CNT_ONE;
                        end
                    end
                end
                FI_ACTIVE: begin
                    if (ev) begin
                        if (inject_count != '1) count_d = inject_count + CNT_ONE;
                        if (duration_q != '0) begin
                            if (cnt == CNT_ONE) state_d = FI_DONE;
                            cnt_d = cnt - CNT_ONE;
                        end
                    end
                end
                default: state_d = FI_IDLE;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state        <= FI_IDLE;
            cnt          <= '0;
            inject_count <= '0;
            mask_q       <= '0;
            pattern_q    <= '0;
            mode_q       <= '0;
            duration_q   <= '0;
            trig_sel_q   <= 1'b0;
            fi_armed     <= 1'b0;
            fi_active    <= 1'b0;
            fi_done      <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            inject_count <= count_d;
            fi_armed     <= (state_d == FI_ARMED);
            fi_active    <= (state_d == FI_ACTIVE);
            fi_done      <= (state_d == FI_DONE);
            if (load_cfg) begin
                mask_q     <= cfg_mask;
                pattern_q  <= cfg_pattern;
                mode_q     <= cfg_mode;
                duration_q <= cfg_duration;
                trig_sel_q <= cfg_trig_sel;
            end
        end
    end

    fault_injection_corrupt #(.WIDTH(WIDTH)) u_corrupt (
        .data      (cdata_in),
        .mask      (mask_q),
        .mode      (mode_q),
        .pattern   (pattern_q),
        .en        (state == FI_ACTIVE),
        .corrupted (out)
    );

endmodule

// File: tb/tb_fault_injection_unit.sv
// tb/tb_fault_injection_unit.sv - table-driven self-checking bench for fault_injection_unit
module tb_fault_injection_unit;

    localparam int WIDTH = 18;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] cdata_in;
    logic             cdata_valid;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] cfg_mask, cfg_pattern;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_delay, cfg_duration;
    logic             cfg_trig_sel;
    logic             arm, disarm;
    logic             fi_armed, fi_active, fi_done;
    logic [CNT_W-1:0] inject_count;

    always #5 clk = ~clk;

    fault_injection_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cdata_in       (cdata_in),
        .cdata_valid    (cdata_valid),
        .out            (out),
        .cfg_mask       (cfg_mask),
        .cfg_mode       (cfg_mode),
        .cfg_pattern    (cfg_pattern),
        .cfg_delay      (cfg_delay),
        .cfg_duration   (cfg_duration),
        .cfg_trig_sel   (cfg_trig_sel),
        .arm            (arm),
        .disarm         (disarm),
        .fi_armed       (fi_armed),
        .fi_active      (fi_active),
        .fi_done        (fi_done),
        .inject_count   (inject_count)
    );

    typedef struct {
        logic             rst, arm, dis, vld;
        logic [WIDTH-1:0] data, mask, pattern, exp_out;
        logic [1:0]       mode;
        logic [CNT_W-1:0] delay, duration, exp_cnt;
        logic             trig;
        logic [2:0]       exp_st;
    } vec_t;

    vec_t vecs[$];

    logic [WIDTH-1:0] s_mask, s_pattern;
    logic [1:0]       s_mode;
    logic [CNT_W-1:0] s_delay, s_duration;
    logic             s_trig;

    int checks = 0;
    int errors = 0;

    task automatic set_cfg(input logic [WIDTH-1:0] m, input logic [1:0] md, input logic [WIDTH-1:0] p,
                           input logic [CNT_W-1:0] dl, input logic [CNT_W-1:0] du, input logic tr);
        s_mask = m; s_mode = md; s_pattern = p; s_delay = dl; s_duration = du; s_trig = tr;
    endtask

    task automatic add(input logic r, input logic a, input logic d, input logic v,
                       input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] eo,
                       input logic [2:0] es, input logic [CNT_W-1:0] ec);
        vec_t x;
        x.rst = r; x.arm = a; x.dis = d; x.vld = v; x.data = data;
        x.mask = s_mask; x.pattern = s_pattern; x.mode = s_mode;
        x.delay = s_delay; x.duration = s_duration; x.trig = s_trig;
        x.exp_out = eo; x.exp_st = es; x.exp_cnt = ec;
        vecs.push_back(x);
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; arm = x.arm; disarm = x.dis; cdata_valid = x.vld; cdata_in = x.data;
        cfg_mask = x.mask; cfg_pattern = x.pattern; cfg_mode = x.mode;
        cfg_delay = x.delay; cfg_duration = x.duration; cfg_trig_sel = x.trig;
    endtask

    task automatic chk(input string name, input int row, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; arm = 1'b0; disarm = 1'b0; cdata_valid = 1'b0; cdata_in = '0;
        cfg_mask = '0; cfg_pattern = '0; cfg_mode = '0;
        cfg_delay = '0; cfg_duration = '0; cfg_trig_sel = 1'b0;
        repeat (2) @(negedge clk);
        cdata_in = 18'h0ABCD;
        #1;
        chk("reset_out", -1, CNT_W'(out), CNT_W'(18'h0ABCD));
        chk("reset_status", -1, CNT_W'({fi_armed, fi_active, fi_done}), 0);
        chk("reset_count", -1, inject_count, 0);
        rst = 1'b0;

        // flip bit 0, immediate start, three cycles
        set_cfg(18'h00001, 2'b10, 18'h0, 0, 3, 1'b0);
        add(0, 1, 0, 0, 18'h15555, 18'h15555, 3'b000, 0);
        add(0, 0, 0, 0, 18'h15555, 18'h15554, 3'b010, 0);
        add(0, 0, 0, 0, 18'h15555, 18'h15554, 3'b010, 1);
        add(0, 0, 0, 0, 18'h15555, 18'h15554, 3'b010, 2);
        add(0, 0, 0, 0, 18'h15555, 18'h15555, 3'b001, 3);
        add(0, 0, 0, 0, 18'h2AAAA, 18'h2AAAA, 3'b001, 3);
        add(0, 0, 1, 0, 18'h2AAAA, 18'h2AAAA, 3'b001, 3);
        add(0, 0, 0, 0, 18'h2AAAA, 18'h2AAAA, 3'b000, 3);

        // stuck-at-0 counted in valid beats, valid every other cycle
        set_cfg(18'h3FFFF, 2'b00, 18'h0, 5, 2, 1'b1);
        add(0, 1, 0, 0, 18'h12345, 18'h12345, 3'b000, 3);
        for (int k = 0; k < 9; k++)
            add(0, 0, 0, (k % 2 == 0), 18'h12345, 18'h12345, 3'b100, 0);
        add(0, 0, 0, 0, 18'h12345, 18'h00000, 3'b010, 0);
        add(0, 0, 0, 1, 18'h12345, 18'h00000, 3'b010, 0);
        add(0, 0, 0, 0, 18'h12345, 18'h00000, 3'b010, 1);
        add(0, 0, 0, 1, 18'h12345, 18'h00000, 3'b010, 1);
        add(0, 0, 0, 0, 18'h12345, 18'h12345, 3'b001, 2);

        // pattern mode, permanent; live cfg changes and re-arm ignored while active
        set_cfg(18'h000FF, 2'b11, 18'h0F0F0, 0, 0, 1'b0);
        add(0, 1, 0, 0, 18'h3FFFF, 18'h3FFFF, 3'b001, 2);
        add(0, 0, 0, 0, 18'h3FFFF, 18'h3FFF0, 3'b010, 0);
        add(0, 0, 0, 0, 18'h00000, 18'h000F0, 3'b010, 1);
        set_cfg(18'h3FFFF, 2'b00, 18'h0, 0, 0, 1'b0);
        add(0, 0, 0, 0, 18'h12345, 18'h123F0, 3'b010, 2);
        add(0, 1, 0, 0, 18'h12345, 18'h123F0, 3'b010, 3);
        add(0, 0, 0, 0, 18'h12345, 18'h123F0, 3'b010, 4);
        add(0, 0, 1, 0, 18'h12345, 18'h123F0, 3'b010, 5);
        add(0, 0, 0, 0, 18'h12345, 18'h12345, 3'b000, 5);

        // arm and disarm together from IDLE
        set_cfg(18'h3FFFF, 2'b01, 18'h0, 0, 0, 1'b0);
        add(0, 1, 1, 0, 18'h00000, 18'h00000, 3'b000, 5);
        add(0, 0, 0, 0, 18'h00000, 18'h00000, 3'b000, 5);

        // second arm in ARMED with a different delay is ignored
        set_cfg(18'h3FFFF, 2'b10, 18'h0, 3, 1, 1'b0);
        add(0, 1, 0, 0, 18'h00000, 18'h00000, 3'b000, 5);
        add(0, 0, 0, 0, 18'h00000, 18'h00000, 3'b100, 0);
        set_cfg(18'h3FFFF, 2'b10, 18'h0, 10, 1, 1'b0);
        add(0, 1, 0, 0, 18'h00000, 18'h00000, 3'b100, 0);
        add(0, 0, 0, 0, 18'h00000, 18'h00000, 3'b100, 0);
        add(0, 0, 0, 0, 18'h00000, 18'h3FFFF, 3'b010, 0);
        add(0, 0, 0, 0, 18'h00000, 18'h00000, 3'b001, 1);

        // reset pulse in the middle of a stuck-at-1 fault
        set_cfg(18'h3FFFF, 2'b01, 18'h0, 0, 0, 1'b0);
        add(0, 1, 0, 0, 18'h00000, 18'h00000, 3'b001, 1);
        add(0, 0, 0, 0, 18'h00000, 18'h3FFFF, 3'b010, 0);
        add(1, 0, 0, 0, 18'h00000, 18'h3FFFF, 3'b010, 1);
        add(0, 0, 0, 0, 18'h00000, 18'h00000, 3'b000, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("out", i, CNT_W'(out), CNT_W'(vecs[i].exp_out));
            chk("status", i, CNT_W'({fi_armed, fi_active, fi_done}), CNT_W'(vecs[i].exp_st));
            chk("inject_count", i, inject_count, vecs[i].exp_cnt);
        end

        // beat-triggered run to completion, bounded wait on fi_done
        @(negedge clk);
        rst = 1'b0; disarm = 1'b0; arm = 1'b1; cdata_valid = 1'b1; cdata_in = 18'h00F00;
        cfg_mask = 18'h3FFFF; cfg_mode = 2'b10; cfg_pattern = '0;
        cfg_delay = 2; cfg_duration = 2; cfg_trig_sel = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        n = 0;
        while (!fi_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", -1, CNT_W'(fi_done), 1);
        chk("done_count", -1, inject_count, 2);
        chk("done_out", -1, CNT_W'(out), CNT_W'(18'h00F00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
